// File: rtl/count_pkg.sv
// Shared types and step constants for the loadable count-down block.
package count_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cnt_state_t;

    localparam logic [1:0] STEP_SMALL = 2'd1;
    localparam logic [1:0] STEP_LARGE = 2'd2;

endpackage

// File: rtl/count_step_sat.sv
// Combinational saturating subtractor: count minus 1 or 2, clamped at zero.
module count_step_sat
    import count_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] count,
    input  logic             ctrl,
    output logic [WIDTH-1:0] next_count,
    output logic             hit_zero
);

    logic [WIDTH:0] step_s;
    logic [WIDTH:0] diff_s;

    // One guard bit makes the borrow visible, so a too-large step clamps instead of wrapping.
    always_comb begin
        step_s = ctrl ? (WIDTH+1)'(STEP_LARGE) : (WIDTH+1)'(STEP_SMALL);
        diff_s = {1'b0, count} - step_s;
        if (diff_s[WIDTH] || (diff_s == {(WIDTH+1){1'b0}})) begin
            hit_zero   = 1'b1;
            next_count = {WIDTH{1'b0}};
        end else begin
            hit_zero   = 1'b0;
            next_count = diff_s[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/count_down_step.sv
// Loadable down-counter stepping by 1 or 2, saturating at zero with a one-cycle done pulse.
// Optional `pause` input is enabled by defining COUNT_DOWN_PAUSE_EN.
module count_down_step
    import count_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_value,
    input  logic             ctrl,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
`ifdef COUNT_DOWN_PAUSE_EN
    ,
    input  logic             pause
`endif
);

    cnt_state_t       state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             ready_q, ready_d;
    logic             load_fire_s;
    logic             pause_s;
    logic [WIDTH-1:0] step_next_s;
    logic             hit_zero_s;

`ifdef COUNT_DOWN_PAUSE_EN
    assign pause_s = pause;
`else
    assign pause_s = 1'b0;
`endif

    count_step_sat #(.WIDTH(WIDTH)) u_step (
        .count      (count_q),
        .ctrl       (ctrl),
        .next_count (step_next_s),
        .hit_zero   (hit_zero_s)
    );

    // Next-state and next-count selection; outputs are decoded from the next state so they register cleanly.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        load_fire_s = load_valid && ready_q;
        case (state_q)
            IDLE, DONE: begin
                if (load_fire_s) begin
                    count_d = load_value;
                    if (load_value != {WIDTH{1'b0}}) begin
                        state_d = RUN;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (pause_s) begin
                    state_d = RUN;
                end else if (hit_zero_s) begin
                    count_d = {WIDTH{1'b0}};
                    state_d = DONE;
                end else begin
                    count_d = step_next_s;
                end
            end
            default: begin
                state_d = IDLE;
                count_d = {WIDTH{1'b0}};
            end
        endcase
        busy_d  = (state_d == RUN);
        done_d  = (state_d == DONE);
        ready_d = (state_d != RUN);
    end

    // State, count and registered status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= {WIDTH{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ready_q <= ready_d;
        end
    end

    assign count      = count_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign load_ready = ready_q;

endmodule

// File: doc/count_down_step.md
# count_down_step

Loadable down-counter that drains a value accepted over a valid/ready load interface, in steps of 1 or 2 selected per cycle by `ctrl`. It saturates at zero and then raises a one-cycle `done` pulse. It pairs with the team's step counters, which count up by 1 or 2: those produce a count, and this block consumes one. Typical uses are timeouts, credit drain and pacing downstream of a step counter.

## Interface
Parameters:
- `WIDTH`, default 4: width of `load_value` and `count`.

Ports:
- `clk`, input, 1: the single clock; all state updates on its rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `load_valid`, input, 1: a load value is offered.
- `load_ready`, output, 1: the block can accept a load.
- `load_value`, input, WIDTH: start value, captured on handshake.
- `ctrl`, input, 1: step select; 1 means step 2, 0 means step 1. Sampled every RUN cycle.
- `count`, output, WIDTH: current registered count.
- `busy`, output, 1: high while in RUN.
- `done`, output, 1: high for exactly one cycle, when count reaches 0.
- `pause`, input, 1: present only with `COUNT_DOWN_PAUSE_EN`.

## Operation
States: IDLE, RUN, DONE.

Reset (asynchronous, `rst_n` = 0):
- State goes to IDLE.
- `count` = 0, `busy` = 0, `done` = 0, `load_ready` = 1.

Handshake:
- `load_ready` = 1 in IDLE and DONE, 0 in RUN.
- A load is accepted when `load_valid && load_ready` at a rising edge.
- `load_valid` in RUN is ignored. The offered value is not captured and does not need to be held.

Transitions:
- IDLE, load accepted, `load_value` != 0: go to RUN, `count` <= `load_value`.
- IDLE, load accepted, `load_value` == 0: go to DONE, `count` <= 0.
- IDLE, no load: stay in IDLE, `count` holds.
- RUN: step = `ctrl` ? 2 : 1.
  - If `count` > step: `count` <= `count` − step, stay in RUN.
  - Otherwise: `count` <= 0, go to DONE. This is the saturating case; an odd count with step 2 clamps to 0 and never wraps.
- DONE, load accepted: same as IDLE with a load (go to RUN or DONE by value).
- DONE, no load: go to IDLE.

Outputs:
- `done` = (state == DONE). It is a registered, state-decoded output, never combinational from inputs.
- `busy` = (state == RUN).

Arithmetic:
- Subtraction is done at WIDTH+1 bits and compared before it is committed, so underflow is impossible.
- A `count` of all-ones is legal.

## Timing
The load is accepted at edge N.
- Edge N gives `count` = V, where V is `load_value`.
- With `ctrl` held at 0: `count` reaches 0 and `done` = 1 at edge N+V.
- With `ctrl` held at 1: `count` reaches 0 and `done` = 1 at edge N+ceil(V/2).
- V = 0: `done` = 1 at edge N and `busy` never rises.
- Back-to-back loads: a load accepted in the DONE cycle starts the next run with no IDLE bubble.
  - If that next V is 0, `done` is high for two consecutive cycles, each marking a separate completion.
- Reset mid-RUN abandons the count immediately. No `done` is generated.

## Configuration
`COUNT_DOWN_PAUSE_EN`:
- Defined: adds the `pause` input. In RUN with `pause` = 1, `count` and the state hold.
  - `ctrl` is ignored while paused.
  - `pause` has no effect in IDLE or DONE.
- Undefined: the port is absent and RUN steps every cycle.

## Structure
- Package `count_pkg` holds:
  - the state enum typedef `cnt_state_t` {IDLE, RUN, DONE};
  - the constants `STEP_SMALL` = 1 and `STEP_LARGE` = 2.
- One sub-module, `count_step_sat`: a combinational saturating subtractor.
  - Inputs: `count`, `ctrl`.
  - Outputs: the next value and a `hit_zero` flag.
  - Instantiated once.

## Test plan
1. WIDTH = 4, `ctrl` = 0, load 5 → `count` 5,4,3,2,1,0 on successive edges; `done` high for 1 cycle with `count` 0; `busy` high for 5 cycles.
2. `ctrl` = 1, load 5 → `count` 5,3,1,0; no wrap to 15; `done` on the 4th edge after the load.
3. Load 0 → `done` the cycle after the handshake; `busy` stays 0.
4. Load 9 (`ctrl` = 0), `load_valid` held with value 3 during RUN → `load_ready` is 0, 3 is not captured; afterwards, 3 offered in the DONE cycle starts a new run with no IDLE cycle.
5. Load 15, assert `rst_n` = 0 asynchronously mid-cycle while `count` = 8 → `count` = 0, state IDLE, `load_ready` = 1 immediately, `done` never asserts.
6. With `COUNT_DOWN_PAUSE_EN`: load 4, `pause` high for 3 cycles at `count` 3 → `count` holds 3, then resumes to 2,1,0.
